cram_loader: RTL

Configuration controller for a chain of `fpgacell` tiles. It accepts the bitstream as parallel words over a valid/ready handshake and serialises it MSB-first onto the cells' CRAM shift chain through `config_en` and `config_data_in`. It also supports non-destructive readback by rotating the chain through itself. The block holds the logic elements in reset (`le_nrst`) until the first complete load, and disables them (`le_en`) while the chain is moving.

---
 rtl/cram_pkg.sv | 18 +
 rtl/cram_loader.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/cram_pkg.sv
// Shared types and sizing helpers for the CRAM configuration controller.
package cram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_WAIT,
    LOAD_SHIFT,
    RB_SHIFT,
    RB_OUT
  } cram_state_t;

  // CRAM bits in one fpgacell: routing, input/output muxes, LUT plus its register-select bit.
  function automatic int cram_cfg_bits(input int bus_width, input int le_inputs,
                                       input int le_outputs, input int lut_size);
    return bus_width * 8 + 4 * (le_inputs + le_outputs) * $clog2(bus_width + 2) + lut_size + 1;
  endfunction

endpackage

// File: rtl/cram_loader.sv
// Serialises a word-wide bitstream onto the fpgacell CRAM shift chain and
// reads it back non-destructively by rotating the chain through itself.
module cram_loader
  import cram_pkg::*;
#(
  parameter int CFG_BITS  = cram_cfg_bits(8, 4, 1, 16),
  parameter int NUM_CELLS = 1,
  parameter int WORD_W    = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start_load,
  input  logic              start_rb,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  input  logic              rb_ready,
  output logic              config_en,
  output logic              config_data_in,
  input  logic              config_data_out,
  output logic              le_nrst,
  output logic              le_en,
  output logic              busy,
  output logic              done
);

  localparam int CHAIN_BITS = CFG_BITS * NUM_CELLS;
  localparam int BL_W       = $clog2(CHAIN_BITS + 1);
  localparam int WL_W       = $clog2(WORD_W + 1);

  cram_state_t       state;
  logic [BL_W-1:0]   bits_left;
  logic [WL_W-1:0]   word_left;
  logic [WL_W-1:0]   word_n;
  logic [WORD_W-1:0] sreg;
  logic [WORD_W-1:0] sreg_rb;

  // Bits carried by the next word: a full word, or whatever remains of the chain.
  function automatic logic [WL_W-1:0] chunk_len(input logic [BL_W-1:0] b);
    if (int'(b) >= WORD_W) return WL_W'(WORD_W);
    return WL_W'(b);
  endfunction

  // Captured bits sit in the low n positions; move them to the top, zero-filling below.
  function automatic logic [WORD_W-1:0] left_align(input logic [WORD_W-1:0] v,
                                                   input logic [WL_W-1:0] n);
    return v << (WORD_W - int'(n));
  endfunction

  assign sreg_rb        = {sreg[WORD_W-2:0], config_data_out};
  assign word_ready     = (state == LOAD_WAIT);
  assign rb_valid       = (state == RB_OUT);
  assign busy           = (state != IDLE);
  assign config_en      = (state == LOAD_SHIFT) || (state == RB_SHIFT);
  assign config_data_in = (state == LOAD_SHIFT) ? sreg[WORD_W-1] :
                          (state == RB_SHIFT)   ? config_data_out : 1'b0;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      bits_left <= '0;
      word_left <= '0;
      word_n    <= '0;
      rb_data   <= '0;
      done      <= 1'b0;
      le_nrst   <= 1'b0;
      le_en     <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_load) begin
            state     <= LOAD_WAIT;
            bits_left <= BL_W'(CHAIN_BITS);
            le_nrst   <= 1'b0;
            le_en     <= 1'b0;
          end else if (start_rb) begin
            state     <= RB_SHIFT;
            bits_left <= BL_W'(CHAIN_BITS);
            word_left <= chunk_len(BL_W'(CHAIN_BITS));
            word_n    <= chunk_len(BL_W'(CHAIN_BITS));
            le_en     <= 1'b0;
          end
        end
        LOAD_WAIT: begin
          if (word_valid) begin
            word_left <= chunk_len(bits_left);
            state     <= LOAD_SHIFT;
          end
        end
        LOAD_SHIFT: begin
          bits_left <= bits_left - BL_W'(1);
          word_left <= word_left - WL_W'(1);
          if (bits_left == BL_W'(1)) begin
            state   <= IDLE;
            done    <= 1'b1;
            le_nrst <= 1'b1;
            le_en   <= 1'b1;
          end else if (word_left == WL_W'(1)) begin
            state <= LOAD_WAIT;
          end
        end
        RB_SHIFT: begin
          bits_left <= bits_left - BL_W'(1);
          word_left <= word_left - WL_W'(1);
          if (word_left == WL_W'(1)) begin
            state   <= RB_OUT;
            rb_data <= left_align(sreg_rb, word_n);
          end
        end
        RB_OUT: begin
          if (rb_ready) begin
            if (bits_left == '0) begin
              state <= IDLE;
              done  <= 1'b1;
              le_en <= 1'b1;
            end else begin
              state     <= RB_SHIFT;
              word_left <= chunk_len(bits_left);
              word_n    <= chunk_len(bits_left);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shift register carries payload only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (state == LOAD_WAIT && word_valid) begin
      sreg <= word_data;
    end else if (state == LOAD_SHIFT) begin
      sreg <= sreg << 1;
    end else if (state == RB_SHIFT) begin
      sreg <= sreg_rb;
    end
  end

endmodule
